// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
//   imem_state_e : LOAD (program load, fetch disabled) / RUN (read-only fetch)
//   INSTR_W      : instruction word width
//   FAULT_INSTR  : word driven on every lane of a faulted response
package imem_pkg;
   typedef enum logic {LOAD = 1'b0, RUN = 1'b1} imem_state_e;
   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] FAULT_INSTR = 32'h0;
endpackage

// File: rtl/imem_bank.sv
// One bank of the instruction memory: synchronous single-port RAM.
// Ports:
//   clk_i   : clock
//   en_i    : port enable (read when we_i=0, write when we_i=1)
//   we_i    : write enable
//   addr_i  : row address within the bank
//   wdata_i : write data
//   rdata_o : registered read data, updated only on an enabled read
// Contents are not reset.
module imem_bank
   import imem_pkg::*;
#(
   parameter int WORDS = 512
) (
   input  logic                     clk_i,
   input  logic                     en_i,
   input  logic                     we_i,
   input  logic [$clog2(WORDS)-1:0] addr_i,
   input  logic [INSTR_W-1:0]       wdata_i,
   output logic [INSTR_W-1:0]       rdata_o
);

   logic [INSTR_W-1:0] mem_q [WORDS];
   logic [INSTR_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) mem_q[addr_i] <= wdata_i;
         else      rdata_q       <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with a program-load port and a valid/ready fetch port.
// Boots in LOAD (accepts word writes), enters RUN on ld_done_i and then
// serves FETCH_W-instruction groups with one cycle of latency.
// Ports:
//   clk_i, aresetn_i       : clock, asynchronous active-low reset
//   ld_valid_i/addr/data   : load word write (LOAD only)
//   ld_done_i              : end of load, enter RUN
//   run_o                  : 1 in RUN
//   req_valid_i/ready_o/pc : fetch request handshake and byte PC
//   rsp_valid_o/ready_i    : response handshake
//   rsp_instr_o            : lane i = instruction at pc+4i (lane 0 in [31:0])
//   rsp_fault_o            : misaligned or out-of-range request
module imem_fetch_port
   import imem_pkg::*;
#(
   parameter int              XLEN      = 64,
   parameter int              DEPTH     = 512,
   parameter int              FETCH_W   = 1,
   parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
   input  logic                       clk_i,
   input  logic                       aresetn_i,
   input  logic                       ld_valid_i,
   input  logic [$clog2(DEPTH)-1:0]   ld_addr_i,
   input  logic [INSTR_W-1:0]         ld_data_i,
   input  logic                       ld_done_i,
   output logic                       run_o,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [XLEN-1:0]            req_pc_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic [INSTR_W*FETCH_W-1:0] rsp_instr_o,
   output logic                       rsp_fault_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int OFFB  = (FETCH_W > 1) ? $clog2(FETCH_W) : 0;
   localparam int ROWS  = DEPTH / FETCH_W;
   localparam int ROW_W = $clog2(ROWS);
   localparam int ROT_W = (FETCH_W > 1) ? OFFB : 1;
   localparam int GRP_W = INSTR_W * FETCH_W;
   localparam logic [XLEN-1:0] FW_X    = XLEN'(FETCH_W);
   // Highest start index whose whole group still fits in memory.
   localparam logic [XLEN-1:0] LIMIT_X = XLEN'(DEPTH - FETCH_W);

   imem_state_e state_q, state_d;

   logic             accept;
   logic             fault_d;
   logic [XLEN-1:0]  idx_x, row_base_x, rot_x;
   logic [ROT_W-1:0] rot_d, rot_q;
   logic             rsp_valid_q, rsp_fault_q, fresh_q;
   logic [GRP_W-1:0] bank_rd, rot_data, hold_q, group;

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) state_q <= LOAD;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == LOAD && ld_done_i) state_d = RUN;
   end

   always_comb begin
      run_o       = (state_q == RUN);
      req_ready_o = (state_q == RUN) && (!rsp_valid_q || rsp_ready_i);
   end

   assign accept = req_valid_i && req_ready_o;

   // ---------------- address / fault decode ----------------
   // If pc < BASE_ADDR the subtraction wraps, but that case faults anyway.
   assign idx_x      = (req_pc_i - BASE_ADDR) >> 2;
   assign fault_d    = (req_pc_i[1:0] != 2'b00) || (req_pc_i < BASE_ADDR) ||
                       (idx_x > LIMIT_X);
   assign row_base_x = idx_x >> OFFB;
   assign rot_x      = idx_x & (FW_X - 1);
   assign rot_d      = ROT_W'(rot_x);

   // ---------------- banks ----------------
   // Word w lives in bank w mod FETCH_W, row w / FETCH_W. For a group starting
   // at bank r, banks below r hold words from the next row.
   for (genvar b = 0; b < FETCH_W; b++) begin : g_bank
      logic [ROW_W-1:0] rd_row, ld_row, addr;
      logic             we, en;

      assign rd_row = ROW_W'(row_base_x + ((rot_x > XLEN'(b)) ? XLEN'(1) : XLEN'(0)));
      assign ld_row = ROW_W'(ld_addr_i >> OFFB);
      assign we     = (state_q == LOAD) && ld_valid_i &&
                      ((ld_addr_i & AW'(FETCH_W - 1)) == AW'(b));
      assign en     = we || accept;
      assign addr   = (state_q == LOAD) ? ld_row : rd_row;

      imem_bank #(.WORDS(ROWS)) u_bank (
         .clk_i   (clk_i),
         .en_i    (en),
         .we_i    (we),
         .addr_i  (addr),
         .wdata_i (ld_data_i),
         .rdata_o (bank_rd[b*INSTR_W +: INSTR_W])
      );
   end

   // ---------------- response / hold ----------------
   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= 1'b0;
         fresh_q     <= 1'b0;
         rot_q       <= '0;
      end else begin
         if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= fault_d;
            rot_q       <= rot_d;
         end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
         end
         // RAM output is fresh only in the cycle right after the read.
         fresh_q <= accept;
      end
   end

   // Doubling the bank vector turns the rotation into a plain part-select.
   logic [2*GRP_W-1:0] dbl;
   assign dbl      = {bank_rd, bank_rd};
   assign rot_data = dbl[rot_q*INSTR_W +: GRP_W];

   always_ff @(posedge clk_i) begin
      if (fresh_q) hold_q <= rot_data;
   end

   assign group       = fresh_q ? rot_data : hold_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_fault_o = rsp_valid_q && rsp_fault_q;
   assign rsp_instr_o = (rsp_valid_q && !rsp_fault_q) ? group : {FETCH_W{FAULT_INSTR}};

endmodule

// File: tb/tb_imem_fetch_port.sv
module tb_imem_fetch_port;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_valid = 1'b0;
   logic [8:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic        ld_done = 1'b0;

   // Instance A: FETCH_W=1, BASE_ADDR=0
   logic        run_a, rdy_a, rv_a, fault_a;
   logic        req_valid_a = 1'b0, rsp_ready_a = 1'b1;
   logic [63:0] pc_a = '0;
   logic [31:0] instr_a;

   // Instance B: FETCH_W=4, BASE_ADDR=0x8000_0000
   logic         run_b, rdy_b, rv_b, fault_b;
   logic         req_valid_b = 1'b0, rsp_ready_b = 1'b1;
   logic [63:0]  pc_b = '0;
   logic [127:0] instr_b;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   imem_fetch_port u_dut_a (
      .clk_i(clk), .aresetn_i(rst_n),
      .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_done_i(ld_done),
      .run_o(run_a), .req_valid_i(req_valid_a), .req_ready_o(rdy_a), .req_pc_i(pc_a),
      .rsp_valid_o(rv_a), .rsp_ready_i(rsp_ready_a), .rsp_instr_o(instr_a), .rsp_fault_o(fault_a)
   );

   imem_fetch_port #(.FETCH_W(4), .BASE_ADDR(64'h8000_0000)) u_dut_b (
      .clk_i(clk), .aresetn_i(rst_n),
      .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_done_i(ld_done),
      .run_o(run_b), .req_valid_i(req_valid_b), .req_ready_o(rdy_b), .req_pc_i(pc_b),
      .rsp_valid_o(rv_b), .rsp_ready_i(rsp_ready_b), .rsp_instr_o(instr_b), .rsp_fault_o(fault_b)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [63:0]  vb_pc    [8];
   logic [127:0] vb_instr [8];
   logic         vb_fault [8];

   initial begin
      vb_pc    = '{64'h8000_0008, 64'h8000_0004, 64'h8000_0014, 64'h8000_07F0,
                   64'h8000_07F4, 64'h0,         64'h8000_0006, 64'h8000_000C};
      vb_instr = '{{32'h114, 32'h110, 32'h10C, 32'h108},
                   {32'h110, 32'h10C, 32'h108, 32'h104},
                   {32'h120, 32'h11C, 32'h118, 32'h114},
                   {32'h8FC, 32'h8F8, 32'h8F4, 32'h8F0},
                   128'h0, 128'h0, 128'h0,
                   {32'h118, 32'h114, 32'h110, 32'h10C}};
      vb_fault = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      // reset state
      step(); step();
      check("rst_run",   {127'b0, run_a},   128'd0);
      check("rst_ready", {127'b0, rdy_a},   128'd0);
      check("rst_valid", {127'b0, rv_a},    128'd0);
      check("rst_fault", {127'b0, fault_a}, 128'd0);
      check("rst_instr", {96'b0, instr_a},  128'd0);
      check("rst_instr_b", instr_b,         128'd0);
      rst_n = 1'b1;

      // program load; a request is pending the whole time and must not be taken
      req_valid_a = 1'b1;
      pc_a        = 64'h0;
      for (int i = 0; i < 512; i++) begin
         ld_valid = 1'b1;
         ld_addr  = 9'(i);
         ld_data  = 32'(i * 4 + 32'h100);
         ld_done  = (i == 511);
         if (i == 5) check("load_ready", {127'b0, rdy_a}, 128'd0);
         step();
      end
      ld_valid = 1'b0;
      ld_done  = 1'b0;
      check("run_rise",    {127'b0, run_a}, 128'd1);
      check("no_early_rsp", {127'b0, rv_a}, 128'd0);
      check("run_ready",   {127'b0, rdy_a}, 128'd1);

      // back-to-back fetches on A
      step(); pc_a = 64'h4;
      check("b2b0_instr", {96'b0, instr_a}, 128'h100);
      check("b2b0_fault", {127'b0, fault_a}, 128'd0);
      step(); pc_a = 64'h7FC;
      check("b2b1_instr", {96'b0, instr_a}, 128'h104);
      check("b2b1_valid", {127'b0, rv_a},   128'd1);
      step(); req_valid_a = 1'b0;
      check("b2b2_instr", {96'b0, instr_a}, 128'h8FC);
      check("b2b2_fault", {127'b0, fault_a}, 128'd0);
      step();
      check("drain_valid", {127'b0, rv_a}, 128'd0);

      // faults on A
      req_valid_a = 1'b1; pc_a = 64'h6;
      step();
      check("misal_fault", {127'b0, fault_a}, 128'd1);
      check("misal_instr", {96'b0, instr_a},  128'd0);
      pc_a = 64'h800;
      step(); req_valid_a = 1'b0;
      check("range_fault", {127'b0, fault_a}, 128'd1);
      check("range_instr", {96'b0, instr_a},  128'd0);
      step();

      // backpressure on A
      req_valid_a = 1'b1; pc_a = 64'h10;
      step();
      check("stall_first", {96'b0, instr_a}, 128'h110);
      rsp_ready_a = 1'b0; pc_a = 64'h20;
      #1;
      check("stall_ready", {127'b0, rdy_a}, 128'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall_valid", {127'b0, rv_a},    128'd1);
         check("stall_instr", {96'b0, instr_a},  128'h110);
         check("stall_fault", {127'b0, fault_a}, 128'd0);
         check("stall_rdy",   {127'b0, rdy_a},   128'd0);
      end
      rsp_ready_a = 1'b1;
      #1;
      check("release_ready", {127'b0, rdy_a}, 128'd1);
      step(); req_valid_a = 1'b0;
      check("release_next", {96'b0, instr_a}, 128'h120);
      step();
      check("release_drain", {127'b0, rv_a}, 128'd0);

      // writes in RUN are ignored
      ld_valid = 1'b1; ld_addr = 9'd0; ld_data = 32'hDEAD;
      step();
      ld_valid = 1'b0;
      req_valid_a = 1'b1; pc_a = 64'h0;
      step(); req_valid_a = 1'b0;
      check("run_write_ignored", {96'b0, instr_a}, 128'h100);
      step();

      // FETCH_W=4 with non-zero base
      for (int k = 0; k < 8; k++) begin
         req_valid_b = 1'b1; pc_b = vb_pc[k];
         step(); req_valid_b = 1'b0;
         check($sformatf("grp%0d_instr", k), instr_b, vb_instr[k]);
         check($sformatf("grp%0d_fault", k), {127'b0, fault_b}, {127'b0, vb_fault[k]});
         check($sformatf("grp%0d_valid", k), {127'b0, rv_b}, 128'd1);
      end
      step();

      // reset mid-stream
      req_valid_a = 1'b1; pc_a = 64'h4;
      step();
      check("pre_rst_instr", {96'b0, instr_a}, 128'h104);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {127'b0, rv_a},    128'd0);
      check("mid_rst_instr", {96'b0, instr_a},  128'd0);
      check("mid_rst_run",   {127'b0, run_a},   128'd0);
      check("mid_rst_ready", {127'b0, rdy_a},   128'd0);
      check("mid_rst_fault", {127'b0, fault_a}, 128'd0);
      req_valid_a = 1'b0;
      step(); step();
      rst_n = 1'b1;
      check("post_rst_run", {127'b0, run_a}, 128'd0);
      ld_done = 1'b1;
      step();
      ld_done = 1'b0;
      check("rerun_run", {127'b0, run_a}, 128'd1);
      req_valid_a = 1'b1; pc_a = 64'h0;
      req_valid_b = 1'b1; pc_b = 64'h8000_0000;
      step();
      req_valid_a = 1'b0; req_valid_b = 1'b0;
      check("retain_a", {96'b0, instr_a}, 128'h100);
      check("retain_b", instr_b, {32'h10C, 32'h108, 32'h104, 32'h100});
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
